// File: rtl/vga_res_pkg.sv
// Resolution codes and controller state encoding shared with the readout and VGA timing generator.
// ST_BLANK only exists when SWITCH_BLANK_EN is defined.
package vga_res_pkg;

  typedef logic [1:0] res_t;

  localparam res_t RES_640X480 = 2'b00;
  localparam res_t RES_800X600 = 2'b01;
  localparam res_t RES_640X350 = 2'b10;
  localparam res_t RES_768X576 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1
`ifdef SWITCH_BLANK_EN
    ,
    ST_BLANK   = 2'd2
`endif
  } state_t;

  // Simultaneous next and prev presses cancel out.
  function automatic res_t res_step(input res_t cur, input logic up, input logic dn);
    res_t result;
    result = cur;
    if (up && !dn)
      result = cur + 2'd1;
    else if (dn && !up)
      result = cur - 2'd1;
    return result;
  endfunction

endpackage

// File: rtl/resolution_ctrl_if.sv
// Button, frame and resolution signals between the controller and its surroundings.
interface resolution_ctrl_if;
  import vga_res_pkg::*;

  logic btn_next;
  logic btn_prev;
  logic frame_end;
  res_t res_sel;
  res_t res_pending;
  logic switch_pending;
  logic res_changed;
  logic blank;

  modport slave (
    input  btn_next, btn_prev, frame_end,
    output res_sel, res_pending, switch_pending, res_changed, blank
  );

  modport master (
    output btn_next, btn_prev, frame_end,
    input  res_sel, res_pending, switch_pending, res_changed, blank
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, hold-time debouncer and one-cycle press pulse.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic        r_press;
  logic [19:0] r_cnt;

  // The press pulse is raised on the same edge the stable level rises, releases are silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= 20'd0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= 20'd0;
      end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_cnt    <= 20'd0;
        r_stable <= r_sync2;
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/resolution_ctrl.sv
// Resolution selector: steps a pending code with debounced buttons and commits it on frame_end.
// Define SWITCH_BLANK_EN to force BLANK_FRAMES frames of blanking after every commit.
module resolution_ctrl
  import vga_res_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter res_t        RES_INIT        = RES_640X480
`ifdef SWITCH_BLANK_EN
  ,
  parameter logic [3:0]  BLANK_FRAMES    = 4'd2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  resolution_ctrl_if.slave  bus
);

  logic   w_next_press;
  logic   w_prev_press;

  state_t r_state;
  state_t w_state_nxt;
  res_t   r_res_sel;
  res_t   w_sel_nxt;
  res_t   r_res_pending;
  res_t   w_pending_nxt;
  logic   r_res_changed;
  logic   w_changed_nxt;
`ifdef SWITCH_BLANK_EN
  logic       r_blank;
  logic       w_blank_nxt;
  logic [3:0] r_blank_cnt;
  logic [3:0] w_cnt_nxt;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_next),
    .o_press (w_next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_prev),
    .o_press (w_prev_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_res_sel     <= RES_INIT;
      r_res_pending <= RES_INIT;
      r_res_changed <= 1'b0;
`ifdef SWITCH_BLANK_EN
      r_blank       <= 1'b0;
      r_blank_cnt   <= 4'd0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_res_sel     <= w_sel_nxt;
      r_res_pending <= w_pending_nxt;
      r_res_changed <= w_changed_nxt;
`ifdef SWITCH_BLANK_EN
      r_blank       <= w_blank_nxt;
      r_blank_cnt   <= w_cnt_nxt;
`endif
    end
  end

  // A commit takes the pre-press pending code; a coinciding press still lands in the pending register.
  always_comb begin
    w_pending_nxt = res_step(r_res_pending, w_next_press, w_prev_press);
    w_sel_nxt     = r_res_sel;
    w_changed_nxt = 1'b0;
    w_state_nxt   = (w_pending_nxt != r_res_sel) ? ST_PENDING : ST_IDLE;
`ifdef SWITCH_BLANK_EN
    w_blank_nxt   = 1'b0;
    w_cnt_nxt     = r_blank_cnt;
`endif
    case (r_state)
      ST_PENDING: begin
        if (bus.frame_end) begin
          w_sel_nxt     = r_res_pending;
          w_changed_nxt = 1'b1;
`ifdef SWITCH_BLANK_EN
          w_state_nxt   = ST_BLANK;
          w_blank_nxt   = 1'b1;
          w_cnt_nxt     = BLANK_FRAMES;
`else
          w_state_nxt   = (w_pending_nxt != r_res_pending) ? ST_PENDING : ST_IDLE;
`endif
        end
      end
`ifdef SWITCH_BLANK_EN
      ST_BLANK: begin
        w_state_nxt = ST_BLANK;
        w_blank_nxt = 1'b1;
        if (r_blank_cnt == 4'd0) begin
          w_blank_nxt = 1'b0;
          w_state_nxt = (w_pending_nxt != r_res_sel) ? ST_PENDING : ST_IDLE;
        end else if (bus.frame_end) begin
          w_cnt_nxt = r_blank_cnt - 4'd1;
          if (r_blank_cnt == 4'd1) begin
            w_blank_nxt = 1'b0;
            w_state_nxt = (w_pending_nxt != r_res_sel) ? ST_PENDING : ST_IDLE;
          end
        end
      end
`endif
      default: begin
      end
    endcase
  end

  assign bus.res_sel        = r_res_sel;
  assign bus.res_pending    = r_res_pending;
  assign bus.switch_pending = (r_res_pending != r_res_sel);
  assign bus.res_changed    = r_res_changed;
`ifdef SWITCH_BLANK_EN
  assign bus.blank          = r_blank;
`else
  assign bus.blank          = 1'b0;
`endif

endmodule

// File: tb/tb_resolution_ctrl.sv
// Directed bench for resolution_ctrl with a scoreboard of expected pending/committed codes.
// Runs with DEBOUNCE_CYCLES=4 and RES_INIT=00.
module tb_resolution_ctrl;
  import vga_res_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  resolution_ctrl_if bus();

  resolution_ctrl #(
    .DEBOUNCE_CYCLES (20'd4),
    .RES_INIT        (2'b00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   totalChecks = 0;
  int   badChecks = 0;
  res_t pendQ[$];
  res_t selQ[$];
  res_t modelPending;
  res_t modelSel;
  res_t prevPending;
  res_t oldPending;
  res_t expVal;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clean press of next or prev: hold long enough to debounce, then release and settle.
  task automatic applyStimulus(input bit isNext);
    @(negedge clk);
    if (isNext) begin
      bus.btn_next = 1'b1;
      modelPending = modelPending + 2'd1;
    end else begin
      bus.btn_prev = 1'b1;
      modelPending = modelPending - 2'd1;
    end
    pendQ.push_back(modelPending);
    repeat (10) @(negedge clk);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulseFrame();
    @(negedge clk);
    bus.frame_end = 1'b1;
    if (modelPending != modelSel) begin
      modelSel = modelPending;
      selQ.push_back(modelSel);
    end
    @(negedge clk);
    bus.frame_end = 1'b0;
  endtask

  // Scoreboard: every pending change and every res_changed pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevPending = bus.res_pending;
    end else begin
      if (bus.res_pending !== prevPending) begin
        if (pendQ.size() == 0) begin
          checkOutput("pending_unexpected", bus.res_pending, prevPending);
        end else begin
          expVal = pendQ.pop_front();
          checkOutput("pending_sb", bus.res_pending, expVal);
        end
        prevPending = bus.res_pending;
      end
      if (bus.res_changed === 1'b1) begin
        if (selQ.size() == 0) begin
          checkOutput("changed_unexpected", bus.res_changed, 1'b0);
        end else begin
          expVal = selQ.pop_front();
          checkOutput("commit_sb", bus.res_sel, expVal);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.btn_next  = 1'b0;
    bus.btn_prev  = 1'b0;
    bus.frame_end = 1'b0;
    modelPending  = 2'b00;
    modelSel      = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("reset_sel", bus.res_sel, 2'b00);
    checkOutput("reset_pending", bus.res_pending, 2'b00);
    checkOutput("reset_switch", bus.switch_pending, 1'b0);
    checkOutput("reset_changed", bus.res_changed, 1'b0);
    checkOutput("reset_blank", bus.blank, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic press and commit");
    applyStimulus(1'b1);
    checkOutput("press_pending", bus.res_pending, 2'b01);
    checkOutput("press_switch", bus.switch_pending, 1'b1);
    checkOutput("press_sel", bus.res_sel, 2'b00);
    pulseFrame();
    checkOutput("commit_sel", bus.res_sel, 2'b01);
    checkOutput("commit_changed", bus.res_changed, 1'b1);
    checkOutput("commit_switch", bus.switch_pending, 1'b0);
    @(negedge clk);
    checkOutput("changed_one_cycle", bus.res_changed, 1'b0);

    $display("[TB] wrap in both directions");
    applyStimulus(1'b1);
    pulseFrame();
    checkOutput("sel_10", bus.res_sel, 2'b10);
    applyStimulus(1'b1);
    checkOutput("wrap_pend_11", bus.res_pending, 2'b11);
    applyStimulus(1'b1);
    checkOutput("wrap_pend_00", bus.res_pending, 2'b00);
    applyStimulus(1'b1);
    checkOutput("wrap_pend_01", bus.res_pending, 2'b01);
    applyStimulus(1'b0);
    checkOutput("prev_pend_00", bus.res_pending, 2'b00);
    applyStimulus(1'b0);
    checkOutput("prev_wrap_11", bus.res_pending, 2'b11);
    pulseFrame();
    checkOutput("sel_11", bus.res_sel, 2'b11);

    $display("[TB] bouncing button");
    for (int i = 0; i < 20; i++) begin
      bus.btn_next = ~bus.btn_next;
      repeat (2) @(negedge clk);
    end
    bus.btn_next = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("bounce_pending", bus.res_pending, 2'b11);
    checkOutput("bounce_switch", bus.switch_pending, 1'b0);

    $display("[TB] press undone before frame end");
    applyStimulus(1'b1);
    checkOutput("undo_switch_hi", bus.switch_pending, 1'b1);
    applyStimulus(1'b0);
    checkOutput("undo_switch_lo", bus.switch_pending, 1'b0);
    pulseFrame();
    for (int i = 0; i < 3; i++) begin
      checkOutput("undo_no_change", bus.res_changed, 1'b0);
      @(negedge clk);
    end
    checkOutput("undo_sel", bus.res_sel, 2'b11);

    $display("[TB] press coincident with frame end");
    applyStimulus(1'b1);
    pulseFrame();
    checkOutput("sel_00", bus.res_sel, 2'b00);
    applyStimulus(1'b1);
    checkOutput("pre_coinc_pending", bus.res_pending, 2'b01);
    @(negedge clk);
    bus.btn_next = 1'b1;
    oldPending   = modelPending;
    modelPending = modelPending + 2'd1;
    pendQ.push_back(modelPending);
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.frame_end = 1'b1;
    modelSel = oldPending;
    selQ.push_back(modelSel);
    @(negedge clk);
    bus.frame_end = 1'b0;
    checkOutput("coinc_sel", bus.res_sel, 2'b01);
    checkOutput("coinc_pending", bus.res_pending, 2'b10);
    checkOutput("coinc_switch", bus.switch_pending, 1'b1);
    repeat (4) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] reset while pending");
    checkOutput("queues_drained", pendQ.size() + selQ.size(), 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_sel", bus.res_sel, 2'b00);
    checkOutput("rst_pending", bus.res_pending, 2'b00);
    checkOutput("rst_switch", bus.switch_pending, 1'b0);
    checkOutput("rst_blank", bus.blank, 1'b0);
    modelPending = 2'b00;
    modelSel     = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0);
    checkOutput("post_rst_pending", bus.res_pending, 2'b11);
    pulseFrame();
    checkOutput("post_rst_sel", bus.res_sel, 2'b11);
    repeat (3) @(negedge clk);

    checkOutput("pendQ_left", pendQ.size(), 0);
    checkOutput("selQ_left", selQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
